// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state encoding.
// The receive side uses the same baud defaults.
package uart_pkg;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200
  localparam int DATA_WIDTH        = 8;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_WAIT_DATA = 3'd1,
    TX_START     = 3'd2,
    TX_DATA      = 3'd3,
    TX_STOP      = 3'd4
  } tx_state_t;
endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tc on the terminal count.
// Shared between the TX and RX engines.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  assign tc = enable && !clear && (cnt_reg == LAST);

  // Wrap at the terminal count so the counter never runs past the bit period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= tc ? '0 : cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter that pulls bytes from a first-word-fall-through-free FIFO read port
// (data valid one cycle after an accepted read) and serialises them LSB first.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int WIDTH        = DATA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fifo_empty,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  input  logic             i_fifo_rd_valid,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_reg, state_next;
  logic             rd_en_reg, rd_en_next;
  logic             tx_reg, tx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic             wait_reg, wait_next;
  logic             baud_clear, baud_en, baud_tc, done;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (baud_clear),
    .enable (baud_en),
    .tc     (baud_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= TX_IDLE;
      rd_en_reg <= 1'b0;
      tx_reg    <= 1'b1;
      shift_reg <= '0;
      bit_reg   <= '0;
      wait_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_en_reg <= rd_en_next;
      tx_reg    <= tx_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en_next = 1'b0;
    tx_next    = tx_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    wait_next  = wait_reg;
    baud_clear = 1'b0;
    baud_en    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        tx_next  = 1'b1;
        bit_next = '0;
        if (!i_fifo_empty) begin
          rd_en_next = 1'b1;
          wait_next  = 1'b0;
          state_next = TX_WAIT_DATA;
        end
      end
      TX_WAIT_DATA: begin
        // Give up after the second edge so an empty-flag race cannot hang the engine.
        baud_clear = 1'b1;
        if (i_fifo_rd_valid) begin
          shift_next = i_fifo_rd_data;
          tx_next    = 1'b0;
          state_next = TX_START;
        end else if (wait_reg) begin
          state_next = TX_IDLE;
        end else begin
          wait_next = 1'b1;
        end
      end
      TX_START: begin
        baud_en = 1'b1;
        if (baud_tc) begin
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          bit_next   = '0;
          state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        baud_en = 1'b1;
        if (baud_tc) begin
          if (bit_reg == LAST_BIT) begin
            tx_next    = 1'b1;
            bit_next   = '0;
            state_next = TX_STOP;
          end else begin
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 1'b1;
          end
        end
      end
      TX_STOP: begin
        baud_en = 1'b1;
        if (baud_tc) begin
          done       = 1'b1;
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign o_fifo_rd_en = rd_en_reg;
  assign o_tx         = tx_reg;
  assign o_busy       = (state_reg != TX_IDLE);
  assign o_done       = done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine with CLKS_PER_BIT=4, WIDTH=8 and a behavioural FIFO.
// Expected bytes are queued when pushed and compared against the decoded serial waveform.
module tb_uart_tx_engine;
  localparam int CPB = 4;
  localparam int W   = 8;
  localparam int FRAME = (W + 2) * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         rd_en;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_valid = 1'b0;
  logic         tx, busy, done;

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fifo_empty    (fifo_empty),
    .o_fifo_rd_en    (rd_en),
    .i_fifo_rd_data  (fifo_data),
    .i_fifo_rd_valid (fifo_valid),
    .o_tx            (tx),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           gap_q[$];
  bit           accept_prev = 0;
  bit           force_ne = 0;
  bit           spur_arm = 0;
  bit           spur_now = 0;

  int           cyc = 0;
  int           rd_cnt = 0;
  int           done_cnt = 0;
  int           frames = 0;
  bit           in_frame = 0;
  int           k = 0;
  logic [W-1:0] exp_byte, got;
  bit           wave_bad, done_ok, have_end;
  int           bad_k, last_end;
  logic         bad_v, exp_lvl;

  // One clock: sample outputs at the falling edge, run the frame monitor, then update the FIFO model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rd_en === 1'b1) rd_cnt++;
    if (done === 1'b1) done_cnt++;
    if (!in_frame && tx === 1'b0) begin
      in_frame = 1; k = 0; wave_bad = 0; done_ok = 0; got = '0;
      if (have_end) gap_q.push_back(cyc - last_end - 1);
      if (exp_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
        exp_byte = '0;
      end else begin
        exp_byte = exp_q.pop_front();
      end
    end
    if (in_frame) begin
      exp_lvl = (k < CPB) ? 1'b0 : ((k < (W + 1) * CPB) ? exp_byte[(k - CPB) / CPB] : 1'b1);
      if (tx !== exp_lvl && !wave_bad) begin wave_bad = 1; bad_k = k; bad_v = tx; end
      if ((k % CPB) == CPB / 2 && k > CPB && k < (W + 1) * CPB) got[(k - CPB) / CPB] = tx;
      if (done === 1'b1 && k == FRAME - 1) done_ok = 1;
      if (k == (W + 1) * CPB && spur_arm) spur_now = 1;
      if (k == FRAME - 1) begin
        tests_run++;
        if (wave_bad) begin
          tests_failed++;
          $display("FAIL frame_wave: byte %02h cycle %0d of frame tx=%b, required %b", exp_byte, bad_k, bad_v, ~bad_v);
        end
        tests_run++;
        if (got !== exp_byte) begin
          tests_failed++;
          $display("FAIL frame_data: decoded %02h, required %02h", got, exp_byte);
        end
        tests_run++;
        if (!done_ok) begin
          tests_failed++;
          $display("FAIL frame_done: o_done not high on cycle %0d of frame %02h, required high", FRAME - 1, exp_byte);
        end
        $display("[TB] frame %02h decoded %02h at cycle %0d", exp_byte, got, cyc);
        in_frame = 0; last_end = cyc; have_end = 1; frames++;
      end
      k++;
    end
    fifo_valid = accept_prev || spur_now;
    if (spur_now) fifo_data = 8'hFF;
    else if (accept_prev) fifo_data = fifo_q.pop_front();
    spur_now = 0;
    accept_prev = (rd_en === 1'b1) && (fifo_q.size() > 0);
    fifo_empty = (fifo_q.size() == 0) && !force_ne;
  endtask

  task automatic push(input logic [W-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin tick(); n++; end
    tests_run++;
    if (frames < target) begin
      tests_failed++;
      $display("FAIL frame_timeout: %0d frames after %0d cycles, required %0d", frames, budget, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b rd_en=%b, required 1 0 0 0", tx, busy, done, rd_en);
    end
    $display("[TB] reset state tx=%b busy=%b", tx, busy);
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int rd0, d0, f0;
    rd0 = rd_cnt; d0 = done_cnt; f0 = frames;
    push(8'h41);
    wait_frames(f0 + 1, 100);
    repeat (10) tick();
    tests_run++;
    if (rd_cnt - rd0 != 1 || done_cnt - d0 != 1 || frames - f0 != 1) begin
      tests_failed++;
      $display("FAIL single_counts: rd_en=%0d done=%0d frames=%0d, required 1 1 1", rd_cnt - rd0, done_cnt - d0, frames - f0);
    end
    $display("[TB] single 0x41 rd_en pulses=%0d done pulses=%0d", rd_cnt - rd0, done_cnt - d0);
  endtask

  task automatic test_back_to_back();
    int rd0, f0;
    rd0 = rd_cnt; f0 = frames;
    have_end = 0; gap_q.delete();
    push(8'h61); push(8'h62); push(8'h63);
    wait_frames(f0 + 3, 200);
    repeat (10) tick();
    tests_run++;
    if (rd_cnt - rd0 != 3) begin
      tests_failed++;
      $display("FAIL btb_rd_en: %0d pulses, required 3", rd_cnt - rd0);
    end
    tests_run++;
    if (gap_q.size() != 2) begin
      tests_failed++;
      $display("FAIL btb_gap_count: %0d gaps, required 2", gap_q.size());
    end
    foreach (gap_q[i]) begin
      tests_run++;
      if (gap_q[i] != 3) begin
        tests_failed++;
        $display("FAIL btb_gap: gap %0d is %0d cycles, required 3", i, gap_q[i]);
      end
      $display("[TB] back-to-back gap %0d = %0d cycles", i, gap_q[i]);
    end
    tests_run++;
    if (fifo_q.size() != 0 || fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL btb_fifo_empty: %0d entries left, required 0", fifo_q.size());
    end
  endtask

  task automatic test_idle_empty();
    int rd0, low, bsy;
    rd0 = rd_cnt; low = 0; bsy = 0;
    repeat (200) begin
      tick();
      if (tx !== 1'b1) low++;
      if (busy !== 1'b0) bsy++;
    end
    tests_run++;
    if (low != 0 || bsy != 0 || rd_cnt != rd0) begin
      tests_failed++;
      $display("FAIL idle_empty: tx-low=%0d busy=%0d rd_en=%0d cycles, required 0 0 0", low, bsy, rd_cnt - rd0);
    end
    $display("[TB] idle 200 cycles rd_en pulses=%0d", rd_cnt - rd0);
  endtask

  task automatic test_reset_mid_frame();
    int n, rd0, f0, act;
    f0 = frames;
    push(8'hA5);
    n = 0;
    while (!(in_frame && k == 4 * CPB + 1) && n < 200) begin tick(); n++; end
    tests_run++;
    if (!(in_frame && k == 4 * CPB + 1)) begin
      tests_failed++;
      $display("FAIL rst_reach_bit3: frame not reached within 200 cycles, required bit 3");
    end
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_pre_bit3: tx=%b, required 0", tx);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: tx=%b busy=%b done=%b rd_en=%b, required 1 0 0 0", tx, busy, done, rd_en);
    end
    $display("[TB] mid-frame reset tx=%b busy=%b", tx, busy);
    in_frame = 0;
    repeat (2) tick();
    rst = 1'b0;
    rd0 = rd_cnt; act = 0;
    repeat (50) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    tests_run++;
    if (act != 0 || rd_cnt != rd0 || frames != f0) begin
      tests_failed++;
      $display("FAIL rst_after: activity=%0d rd_en=%0d frames=%0d, required 0 0 0", act, rd_cnt - rd0, frames - f0);
    end
  endtask

  task automatic test_timeout();
    int rd0, low, f0;
    rd0 = rd_cnt; low = 0; f0 = frames;
    force_ne = 1; fifo_empty = 1'b0;
    repeat (30) begin
      tick();
      if (tx !== 1'b1) low++;
    end
    force_ne = 0; fifo_empty = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (rd_cnt - rd0 != 10) begin
      tests_failed++;
      $display("FAIL timeout_retry: %0d rd_en pulses in 30 cycles, required 10", rd_cnt - rd0);
    end
    tests_run++;
    if (low != 0 || frames != f0) begin
      tests_failed++;
      $display("FAIL timeout_line: tx-low=%0d frames=%0d, required 0 0", low, frames - f0);
    end
    $display("[TB] timeout rd_en pulses=%0d", rd_cnt - rd0);
  endtask

  task automatic test_spurious_valid();
    int f0;
    f0 = frames;
    spur_arm = 1;
    push(8'h00);
    wait_frames(f0 + 1, 100);
    spur_arm = 0;
    repeat (20) tick();
    tests_run++;
    if (frames != f0 + 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL spurious_extra: %0d frames, required 1", frames - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_idle_empty();
    test_reset_mid_frame();
    test_timeout();
    test_spurious_valid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
